// File: rtl/regfile_bist.sv
// Register file BIST: fills all registers with a seeded pattern, reads them back in pairs,
// and reports pass/fail plus the first mismatching address.
module regfile_bist #(
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 32,
  parameter int ZERO_R0  = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [DATA_W-1:0] seed,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ADDR_W-1:0] fail_addr,
  output logic              RegWrite,
  output logic [ADDR_W-1:0] WriteReg,
  output logic [DATA_W-1:0] WriteData,
  output logic [ADDR_W-1:0] ReadReg1,
  output logic [ADDR_W-1:0] ReadReg2,
  input  logic [DATA_W-1:0] ReadData1,
  input  logic [DATA_W-1:0] ReadData2
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_WRITE = 2'd1;
  localparam logic [1:0] S_READ  = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [ADDR_W-1:0] idxOdd;
  logic [1:0]        modeR;
  logic [DATA_W-1:0] seedR;
  logic              lastWrite;
  logic              lastPair;
  logic              mis1;
  logic              mis2;

  function automatic logic [DATA_W-1:0] patFn(input logic [1:0] m,
                                               input logic [DATA_W-1:0] s,
                                               input logic [ADDR_W-1:0] a);
    logic [DATA_W-1:0] ax;
    ax = DATA_W'(a);
    case (m)
      2'd0:    patFn = s;
      2'd1:    patFn = ax ^ s;
      2'd2:    patFn = (DATA_W'(1) << ax[4:0]) ^ s;
      default: patFn = ~ax ^ s;
    endcase
  endfunction

  function automatic logic [DATA_W-1:0] expFn(input logic [1:0] m,
                                               input logic [DATA_W-1:0] s,
                                               input logic [ADDR_W-1:0] a);
    if (ZERO_R0 != 0 && a == '0) expFn = '0;
    else                         expFn = patFn(m, s, a);
  endfunction

  assign idxOdd    = idx + ADDR_W'(1);
  assign lastWrite = (idx == ADDR_W'(NUM_REGS - 1));
  assign lastPair  = (idx == ADDR_W'(NUM_REGS - 2));
  assign mis1      = (ReadData1 != expFn(modeR, seedR, idx));
  assign mis2      = (ReadData2 != expFn(modeR, seedR, idxOdd));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= S_IDLE;
      idx       <= '0;
      modeR     <= '0;
      seedR     <= '0;
      pass      <= 1'b0;
      fail_addr <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            modeR     <= mode;
            seedR     <= seed;
            pass      <= 1'b0;
            fail_addr <= '0;
            idx       <= '0;
            state     <= S_WRITE;
          end
        end
        S_WRITE: begin
          if (lastWrite) begin
            idx   <= '0;
            state <= S_READ;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        S_READ: begin
          // Port 1 wins when both halves of the pair mismatch.
          if (mis1) begin
            pass      <= 1'b0;
            fail_addr <= idx;
            state     <= S_DONE;
          end else if (mis2) begin
            pass      <= 1'b0;
            fail_addr <= idxOdd;
            state     <= S_DONE;
          end else if (lastPair) begin
            pass  <= 1'b1;
            idx   <= '0;
            state <= S_DONE;
          end else begin
            idx <= idx + ADDR_W'(2);
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Port outputs decode from registered state only, so reset clears them without a clock.
  always_comb begin
    busy      = (state == S_WRITE) || (state == S_READ);
    done      = (state == S_DONE);
    RegWrite  = (state == S_WRITE);
    WriteReg  = '0;
    WriteData = '0;
    ReadReg1  = '0;
    ReadReg2  = '0;
    if (state == S_WRITE) begin
      WriteReg  = idx;
      WriteData = patFn(modeR, seedR, idx);
    end
    if (state == S_READ) begin
      ReadReg1 = idx;
      ReadReg2 = idxOdd;
    end
  end

endmodule

// File: tb/tb_regfile_bist.sv
// Randomized bench for regfile_bist: behavioural register file with r0 hardwired to zero and
// injectable stuck-at-1 faults; one DUT per ZERO_R0 setting shares the register file.
module tb_regfile_bist;
  localparam int NR = 32;
  localparam int AW = 5;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          start;
  logic [1:0]    mode;
  logic [DW-1:0] seed;

  logic          busyA, doneA, passA, RegWriteA;
  logic [AW-1:0] failA, WriteRegA, RR1A, RR2A;
  logic [DW-1:0] WriteDataA, RD1A, RD2A;
  logic          busyB, doneB, passB, RegWriteB;
  logic [AW-1:0] failB, WriteRegB, RR1B, RR2B;
  logic [DW-1:0] WriteDataB, RD1B, RD2B;

  logic [DW-1:0] regs  [NR];
  logic [DW-1:0] fault [NR];

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_bist #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_R0(1)) dutA (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .busy(busyA), .done(doneA), .pass(passA), .fail_addr(failA),
    .RegWrite(RegWriteA), .WriteReg(WriteRegA), .WriteData(WriteDataA),
    .ReadReg1(RR1A), .ReadReg2(RR2A), .ReadData1(RD1A), .ReadData2(RD2A));

  regfile_bist #(.NUM_REGS(NR), .ADDR_W(AW), .DATA_W(DW), .ZERO_R0(0)) dutB (
    .clk(clk), .reset(reset), .start(start), .mode(mode), .seed(seed),
    .busy(busyB), .done(doneB), .pass(passB), .fail_addr(failB),
    .RegWrite(RegWriteB), .WriteReg(WriteRegB), .WriteData(WriteDataB),
    .ReadReg1(RR1B), .ReadReg2(RR2B), .ReadData1(RD1B), .ReadData2(RD2B));

  always @(posedge clk) if (RegWriteA) regs[WriteRegA] <= WriteDataA;

  always_comb begin
    RD1A = ((RR1A == '0) ? '0 : regs[RR1A]) | fault[RR1A];
    RD2A = ((RR2A == '0) ? '0 : regs[RR2A]) | fault[RR2A];
    RD1B = ((RR1B == '0) ? '0 : regs[RR1B]) | fault[RR1B];
    RD2B = ((RR2B == '0) ? '0 : regs[RR2B]) | fault[RR2B];
  end

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%h want=%h", tag, got, want);
    end
  endtask

  function automatic logic [31:0] mpat(input logic [1:0] m, input logic [31:0] s, input int a);
    case (m)
      2'd0:    return s;
      2'd1:    return 32'(a) ^ s;
      2'd2:    return (32'h1 << a) ^ s;
      default: return ~32'(a) ^ s;
    endcase
  endfunction

  // Expected outcome from what the faulty register file will return for each address.
  task automatic predict(input logic [1:0] m, input logic [31:0] s, input bit zr,
                         output bit p, output int fa, output int dc);
    logic [31:0] got, want;
    p = 1'b1; fa = 0; dc = 49;
    for (int k = 0; k < NR / 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        int a = 2 * k + j;
        got  = ((a == 0) ? 32'h0 : mpat(m, s, a)) | fault[a];
        want = (zr && a == 0) ? 32'h0 : mpat(m, s, a);
        if (got !== want) begin
          p = 1'b0; fa = a; dc = 34 + k;
          return;
        end
      end
    end
  endtask

  task automatic runTest(input string name, input logic [1:0] m, input logic [31:0] s,
                         input int restartAt, output logic [31:0] lastData);
    bit pA, pB;
    int faA, faB, dcExpA, dcExpB;
    int dcA = -1, dcB = -1, doneCntA = 0, wrErr = 0, busyErr = 0;
    predict(m, s, 1'b1, pA, faA, dcExpA);
    predict(m, s, 1'b0, pB, faB, dcExpB);
    lastData = '0;
    @(negedge clk);
    mode = m; seed = s; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0; mode = 2'($urandom); seed = $urandom;
    for (int c = 1; c <= 60; c++) begin
      @(negedge clk);
      if (c == restartAt + 1) begin start = 1'b0; mode = 2'($urandom); end
      if (c == restartAt) begin start = 1'b1; seed = $urandom; end
      if (doneA) begin doneCntA++; if (dcA < 0) dcA = c; end
      if (doneB && dcB < 0) dcB = c;
      if (busyA !== (c < dcExpA)) busyErr++;
      if (c <= NR) begin
        if (RegWriteA !== 1'b1 || WriteRegA !== AW'(c - 1) || WriteDataA !== mpat(m, s, c - 1))
          wrErr++;
        if (c == NR) lastData = WriteDataA;
      end else if (RegWriteA !== 1'b0) begin
        wrErr++;
      end
      if (c <= NR && (RegWriteB !== RegWriteA || WriteRegB !== WriteRegA || WriteDataB !== WriteDataA))
        wrErr++;
    end
    checkVal({name, ".wrErr"},   wrErr, 0);
    checkVal({name, ".busyErr"}, busyErr, 0);
    checkVal({name, ".doneCyc"}, dcA, dcExpA);
    checkVal({name, ".doneCnt"}, doneCntA, 1);
    checkVal({name, ".pass"},    {31'b0, passA}, {31'b0, pA});
    checkVal({name, ".failAddr"}, {27'b0, failA}, faA);
    checkVal({name, ".doneCycB"}, dcB, dcExpB);
    checkVal({name, ".passB"},   {31'b0, passB}, {31'b0, pB});
    checkVal({name, ".failAddrB"}, {27'b0, failB}, faB);
  endtask

  task automatic clearFaults();
    for (int i = 0; i < NR; i++) fault[i] = '0;
  endtask

  initial begin
    logic [31:0] ld;
    for (int i = 0; i < NR; i++) regs[i] = '0;
    clearFaults();
    reset = 1'b1; start = 1'b0; mode = '0; seed = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkVal("rst.busy",      {31'b0, busyA}, 0);
    checkVal("rst.done",      {31'b0, doneA}, 0);
    checkVal("rst.pass",      {31'b0, passA}, 0);
    checkVal("rst.failAddr",  {27'b0, failA}, 0);
    checkVal("rst.RegWrite",  {31'b0, RegWriteA}, 0);
    checkVal("rst.WriteReg",  {27'b0, WriteRegA}, 0);
    checkVal("rst.WriteData", WriteDataA, 0);
    checkVal("rst.ReadReg1",  {27'b0, RR1A}, 0);
    checkVal("rst.ReadReg2",  {27'b0, RR2A}, 0);
    reset = 1'b0;
    @(negedge clk);

    runTest("m1", 2'd1, 32'h0, -1, ld);
    runTest("m3", 2'd3, 32'hA5A5A5A5, -1, ld);
    checkVal("m3.r31data", ld, 32'h5A5A5A45);

    fault[12] = 32'h1;
    runTest("m2f12", 2'd2, 32'h0, -1, ld);
    checkVal("m2f12.failAddrConst", {27'b0, failA}, 12);
    fault[13] = 32'h1;
    runTest("f12f13", 2'd2, 32'h0, -1, ld);
    fault[12] = 32'h0;
    runTest("f13", 2'd2, 32'h0, -1, ld);
    clearFaults();

    runTest("restart", 2'($urandom), $urandom, 20, ld);

    // Reset partway through a write phase must drop the ports without a clock edge.
    @(negedge clk);
    mode = 2'd1; seed = $urandom; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    repeat (9) @(posedge clk);
    #2 checkVal("midrst.busyBefore", {31'b0, busyA}, 1);
    reset = 1'b1;
    #1;
    checkVal("midrst.RegWrite", {31'b0, RegWriteA}, 0);
    checkVal("midrst.busy",     {31'b0, busyA}, 0);
    @(negedge clk);
    reset = 1'b0;
    repeat (3) @(negedge clk);
    checkVal("midrst.stayIdle", {31'b0, busyA}, 0);
    runTest("afterRst", 2'd1, 32'h0, -1, ld);

    runTest("m0ones", 2'd0, 32'hFFFFFFFF, -1, ld);
    checkVal("m0ones.failCycB", {31'b0, passB}, 0);

    for (int r = 0; r < 5; r++) begin
      clearFaults();
      if ($urandom_range(1, 0) == 1)
        fault[$urandom_range(NR - 1, 0)] = 32'h1 << $urandom_range(31, 0);
      runTest($sformatf("rnd%0d", r), 2'($urandom), $urandom, -1, ld);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
